bf_result_checker: RTL
======================

# bf_result_checker

Synthesizable result-drain and self-check engine for the Bellman-Ford core. On the core's rising Finish it walks the output-distance memory from address 0 to DEPTH-1, compares every entry with an expected-result memory, and streams each entry out on a valid/ready port tagged with index, infinity flag and mismatch flag. On the core's rising NegCycle it aborts the scan and reports the negative cycle. It replaces file-dump checking with an in-fabric pass/fail, generalised in depth, data width, read latency and infinity encoding.

## Interface
- ADDR_W, 13: memory address width.
- DATA_W, 16: distance word width.
- DEPTH, 8192: entries scanned, 1..2^ADDR_W.
- READ_LAT, 0: memory read latency in cycles, 0 (combinational) or 1 (registered).
- INF_VALUE, {DATA_W{1'b1}}: encoding of unreachable distance.

- clock, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- finish, in, 1: level from core; rising edge starts a scan.
- neg_cycle, in, 1: level from core; rising edge aborts or flags.
- expect_neg, in, 1: negative cycle expected for this test (sampled at start edge).
- RMAR, out, ADDR_W: result-memory read address.
- RMDR, in, DATA_W: result-memory read data.
- EMAR, out, ADDR_W: expected-memory read address (always equals RMAR).
- EMDR, in, DATA_W: expected-memory read data.
- out_valid, out, 1: stream entry valid.
- out_ready, in, 1: sink accepts entry.
- out_index, out, ADDR_W: entry address.
- out_data, out, DATA_W: result value.
- out_inf, out, 1: out_data == INF_VALUE.
- out_mismatch, out, 1: result != expected.
- busy, out, 1: scan in progress.
- done, out, 1: sticky, check complete.
- neg_seen, out, 1: sticky, negative cycle reported.
- pass, out, 1: valid only while done.
- mismatch_count, out, ADDR_W+1: number of mismatching entries.
- first_mismatch, out, ADDR_W: lowest mismatching address (0 when none).

## Operation
- Edge detect: finish_q and neg_q are registered; an event is level & ~level_q. Both are cleared by reset.
- States are IDLE, READ, WAIT, EMIT and DONE.
- IDLE to READ on a finish event, if there is no neg event in the same cycle. On entry: addr=0, counters cleared, expect_neg latched, busy=1.
- READ drives RMAR=EMAR=addr. If READ_LAT=0, capture data in the same cycle and go to EMIT. If READ_LAT=1, go to WAIT, capture the next cycle, then go to EMIT.
- Capture sets out_data=RMDR, out_inf=(RMDR==INF_VALUE) and out_mismatch=(RMDR!=EMDR). Infinity matches only infinity.
- In EMIT, out_valid=1. On out_valid&out_ready, update mismatch_count and first_mismatch (first mismatch only), then increment addr. If addr==DEPTH-1, go to DONE; otherwise go to READ.
- A neg event in any state except DONE sets neg_seen, drops out_valid the same edge, and goes to DONE. A scan interrupted this way reports only the entries accepted so far.
- Simultaneous finish and neg events are treated as neg: neg_seen=1 and state goes to DONE.
- pass = (neg_seen==expect_neg) && (neg_seen || mismatch_count==0).
- DONE holds all results, with done=1 and busy=0. A new finish event clears the results and restarts the scan. Level-high finish without a new edge does not restart.
- The address does not wrap: addr never exceeds DEPTH-1.

## Timing
- Reset values: state IDLE; RMAR=EMAR=0; out_valid=0; out_index=0; out_data=0; out_inf=0; out_mismatch=0; busy=0; done=0; neg_seen=0; pass=0; mismatch_count=0; first_mismatch=0.
- Reset is effective mid-scan: everything returns to reset values on the next edge and no partial entry is presented.
- out_valid rises 2 cycles after the finish edge when READ_LAT=0, or 3 cycles after when READ_LAT=1.
- While out_valid=1 and out_ready=0, out_index, out_data and the flags are held stable.
- Throughput with out_ready held at 1 is one entry per 2 cycles (READ_LAT=0) or one per 3 cycles (READ_LAT=1).
- done asserts the cycle after the last handshake, or the cycle after a neg event.

## Test plan
- DEPTH=8, READ_LAT=0, results equal expected, entry 3 = INF: 8 entries out in order, out_inf only at index 3; done=1, pass=1, mismatch_count=0.
- DEPTH=8, expected differs at addresses 2 and 5: out_mismatch at index 2 and 5; mismatch_count=2, first_mismatch=2, pass=0. Also cover result=INF vs expected=0: counts as a mismatch.
- READ_LAT=1 with out_ready toggling randomly: no entry lost or duplicated; data held stable while stalled; first out_valid 3 cycles after finish.
- Neg event after 3 accepted entries, expect_neg=1: out_valid drops the same edge; done=1, neg_seen=1, pass=1. Repeat with expect_neg=0: pass=0.
- Finish and neg rise in the same cycle: no entry is emitted; neg_seen=1; done the next cycle.
- Reset asserted mid-scan at index 4: all outputs return to reset values. A following finish edge produces a full clean scan starting at index 0.

Source files
------------

// File: rtl/bf_result_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : bf_result_checker_if
// Brief    : Control, memory-read and result-stream bundle of the checker.
// Revision : 1.0 - initial release
// ============================================================================
interface bf_result_checker_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic              finish;
    logic              neg_cycle;
    logic              expect_neg;
    logic [ADDR_W-1:0] RMAR;
    logic [DATA_W-1:0] RMDR;
    logic [ADDR_W-1:0] EMAR;
    logic [DATA_W-1:0] EMDR;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_inf;
    logic              out_mismatch;
    logic              busy;
    logic              done;
    logic              neg_seen;
    logic              pass;
    logic [ADDR_W:0]   mismatch_count;
    logic [ADDR_W-1:0] first_mismatch;

    modport slave (
        input  finish, neg_cycle, expect_neg, RMDR, EMDR, out_ready,
        output RMAR, EMAR, out_valid, out_index, out_data, out_inf, out_mismatch,
               busy, done, neg_seen, pass, mismatch_count, first_mismatch
    );

    modport master (
        output finish, neg_cycle, expect_neg, RMDR, EMDR, out_ready,
        input  RMAR, EMAR, out_valid, out_index, out_data, out_inf, out_mismatch,
               busy, done, neg_seen, pass, mismatch_count, first_mismatch
    );
endinterface
`default_nettype wire

// File: rtl/bf_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : bf_result_checker
// Brief    : Drains the Bellman-Ford distance memory, compares against expected
//            results, streams tagged entries and reports pass/fail.
// Revision : 1.0 - initial release
// ============================================================================
module bf_result_checker #(
    parameter int                ADDR_W    = 13,
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 8192,
    parameter int                READ_LAT  = 0,
    parameter logic [DATA_W-1:0] INF_VALUE = {DATA_W{1'b1}}
) (
    input  logic               clock,
    input  logic               reset,
    bf_result_checker_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_finish_q;
    logic              r_neg_q;
    logic              w_finish_ev;
    logic              w_neg_ev;
    logic              w_start;
    logic              w_capture;
    logic              w_accept;
    logic              w_neg_take;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_out_index;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_inf;
    logic              r_out_mismatch;
    logic              r_expect_neg;
    logic              r_neg_seen;
    logic [ADDR_W:0]   r_mismatch_count;
    logic [ADDR_W-1:0] r_first_mismatch;

    assign w_finish_ev = bus.finish & ~r_finish_q;
    assign w_neg_ev    = bus.neg_cycle & ~r_neg_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_capture  = 1'b0;
        w_accept   = 1'b0;
        w_neg_take = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_finish_ev) begin
                    w_start = 1'b1;
                    w_next  = S_READ;
                end
            end
            S_READ: begin
                if (READ_LAT == 0) begin
                    w_capture = 1'b1;
                    w_next    = S_EMIT;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_capture = 1'b1;
                w_next    = S_EMIT;
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    w_accept = 1'b1;
                    w_next   = (r_addr == c_last_addr) ? S_DONE : S_READ;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // A neg event wins over everything, including a finish edge in the same cycle.
        if (w_neg_ev && ((r_state != S_DONE) || w_start)) begin
            w_neg_take = 1'b1;
            w_capture  = 1'b0;
            w_accept   = 1'b0;
            w_next     = S_DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_finish_q       <= 1'b0;
            r_neg_q          <= 1'b0;
            r_addr           <= '0;
            r_out_index      <= '0;
            r_out_data       <= '0;
            r_out_inf        <= 1'b0;
            r_out_mismatch   <= 1'b0;
            r_expect_neg     <= 1'b0;
            r_neg_seen       <= 1'b0;
            r_mismatch_count <= '0;
            r_first_mismatch <= '0;
        end else begin
            r_finish_q <= bus.finish;
            r_neg_q    <= bus.neg_cycle;
            if (w_start) begin
                r_addr           <= '0;
                r_mismatch_count <= '0;
                r_first_mismatch <= '0;
                r_expect_neg     <= bus.expect_neg;
                r_neg_seen       <= 1'b0;
            end
            if (w_neg_take) begin
                r_neg_seen <= 1'b1;
            end
            if (w_capture) begin
                r_out_index    <= r_addr;
                r_out_data     <= bus.RMDR;
                r_out_inf      <= (bus.RMDR == INF_VALUE);
                r_out_mismatch <= (bus.RMDR != bus.EMDR);
            end
            if (w_accept) begin
                if (r_out_mismatch) begin
                    r_mismatch_count <= r_mismatch_count + (ADDR_W + 1)'(1);
                    if (r_mismatch_count == '0) begin
                        r_first_mismatch <= r_out_index;
                    end
                end
                // Hold at the last address instead of wrapping.
                if (r_addr != c_last_addr) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign bus.RMAR           = r_addr;
    assign bus.EMAR           = r_addr;
    assign bus.out_valid      = (r_state == S_EMIT);
    assign bus.out_index      = r_out_index;
    assign bus.out_data       = r_out_data;
    assign bus.out_inf        = r_out_inf;
    assign bus.out_mismatch   = r_out_mismatch;
    assign bus.busy           = (r_state == S_READ) || (r_state == S_WAIT) || (r_state == S_EMIT);
    assign bus.done           = (r_state == S_DONE);
    assign bus.neg_seen       = r_neg_seen;
    assign bus.pass           = (r_state == S_DONE) && (r_neg_seen == r_expect_neg)
                                && (r_neg_seen || (r_mismatch_count == '0));
    assign bus.mismatch_count = r_mismatch_count;
    assign bus.first_mismatch = r_first_mismatch;

endmodule
`default_nettype wire
